sia_rx_wbs: RTL and testbench

//  Wishbone B4 pipelined slave front-end for the SIA receive path. Holds the

---
 rtl/sia_pkg.sv | 29 ++
 rtl/sia_rx_wbs_if.sv | 24 ++
 rtl/sia_rx_wbs.sv | 164 ++++++++++++++++
 tb/tb_sia_rx_wbs.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sia_pkg.sv
// Shared constants for the SIA receive-path bus front-end.
package sia_pkg;

  // Register word addresses
  localparam logic [2:0] SIA_RX_DAT    = 3'd0;
  localparam logic [2:0] SIA_RX_STATUS = 3'd1;
  localparam logic [2:0] SIA_RX_CONFIG = 3'd2;
  localparam logic [2:0] SIA_RX_BAUDLO = 3'd3;
  localparam logic [2:0] SIA_RX_BAUDHI = 3'd4;

  // STATUS bit positions
  localparam int unsigned STAT_NE_BIT   = 0;
  localparam int unsigned STAT_FULL_BIT = 1;
  localparam int unsigned STAT_OVF_BIT  = 2;
  localparam int unsigned STAT_IE_BIT   = 3;

  // CONFIG bit positions
  localparam int unsigned CFG_BITS_W   = 6;
  localparam int unsigned CFG_EEDD_BIT = 6;
  localparam int unsigned CFG_EEDC_BIT = 7;

  localparam logic [CFG_BITS_W-1:0] CFG_BITS_RST = 6'd8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } wbs_state_e;

endpackage

// File: rtl/sia_rx_wbs_if.sv
// Wishbone B4 pipelined slave bus bundle; signal suffixes are from the slave side.
interface sia_rx_wbs_if #(
  parameter int unsigned DW = 16
);
  logic            cyc_i;
  logic            stb_i;
  logic            we_i;
  logic [2:0]      adr_i;
  logic [DW/8-1:0] sel_i;
  logic [DW-1:0]   dat_i;
  logic [DW-1:0]   dat_o;
  logic            ack_o;
  logic            stall_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o, stall_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o, stall_o
  );
endinterface

// File: rtl/sia_rx_wbs.sv
// SIA receive-path Wishbone slave: config registers, RX FIFO drain, status, IRQ.
module sia_rx_wbs
  import sia_pkg::*;
#(
  parameter int unsigned SHIFT_REG_WIDTH = 16,
  parameter int unsigned BAUD_RATE_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  sia_rx_wbs_if.slave                wb,
  output logic                       irq_o,
  output logic [CFG_BITS_W-1:0]      bits_o,
  output logic [BAUD_RATE_WIDTH-1:0] baud_o,
  output logic                       eedd_o,
  output logic                       eedc_o,
  output logic                       rxq_pop_o,
  output logic                       rxq_oe_o,
  input  logic [SHIFT_REG_WIDTH-1:0] rxq_dat_i,
  input  logic                       rxq_full_i,
  input  logic                       rxq_not_empty_i
);

  localparam int unsigned NB = SHIFT_REG_WIDTH / 8;

  wbs_state_e                 state_q, state_d;
  logic                       ack_q, ack_d;
  logic                       stall_q, stall_d;
  logic [SHIFT_REG_WIDTH-1:0] dat_q, dat_d;
  logic                       irq_q, irq_d;
  logic [CFG_BITS_W-1:0]      bits_q, bits_d;
  logic [BAUD_RATE_WIDTH-1:0] baud_q, baud_d;
  logic                       eedd_q, eedd_d;
  logic                       eedc_q, eedc_d;
  logic                       ovf_q, ovf_d;
  logic                       ie_q, ie_d;
  logic                       full_prev_q, full_prev_d;

  logic req;
  logic accept;
  logic rd_pop;
  logic ovf_clr;

  // Next-state, register-file update and read-data capture
  always_comb begin
    req         = wb.cyc_i & wb.stb_i;
    accept      = (state_q == ST_IDLE) & req;
    rd_pop      = accept & ~wb.we_i & (wb.adr_i == SIA_RX_DAT) & rxq_not_empty_i;
    ovf_clr     = 1'b0;
    state_d     = state_q;
    ack_d       = 1'b0;
    stall_d     = 1'b0;
    dat_d       = dat_q;
    bits_d      = bits_q;
    baud_d      = baud_q;
    eedd_d      = eedd_q;
    eedc_d      = eedc_q;
    ie_d        = ie_q;

    if (state_q == ST_ACK) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      state_d = ST_ACK;
      ack_d   = 1'b1;
      stall_d = 1'b1;
      dat_d   = '0;
      if (wb.we_i) begin
        case (wb.adr_i)
          SIA_RX_STATUS: begin
            if (wb.sel_i[0]) begin
              ie_d    = wb.dat_i[STAT_IE_BIT];
              ovf_clr = wb.dat_i[STAT_OVF_BIT];
            end
          end
          SIA_RX_CONFIG: begin
            if (wb.sel_i[0]) begin
              bits_d = wb.dat_i[CFG_BITS_W-1:0];
              eedd_d = wb.dat_i[CFG_EEDD_BIT];
              eedc_d = wb.dat_i[CFG_EEDC_BIT];
            end
          end
          SIA_RX_BAUDLO: begin
            for (int unsigned b = 0; b < NB; b++) begin
              if (wb.sel_i[b]) baud_d[b*8 +: 8] = wb.dat_i[b*8 +: 8];
            end
          end
          SIA_RX_BAUDHI: begin
            for (int unsigned b = 0; b < NB; b++) begin
              if (wb.sel_i[b]) baud_d[SHIFT_REG_WIDTH + b*8 +: 8] = wb.dat_i[b*8 +: 8];
            end
          end
          default: ;
        endcase
      end else begin
        case (wb.adr_i)
          SIA_RX_DAT: begin
            if (rxq_not_empty_i) dat_d = rxq_dat_i;
          end
          SIA_RX_STATUS: begin
            dat_d[STAT_NE_BIT]   = rxq_not_empty_i;
            dat_d[STAT_FULL_BIT] = rxq_full_i;
            dat_d[STAT_OVF_BIT]  = ovf_q;
            dat_d[STAT_IE_BIT]   = ie_q;
          end
          SIA_RX_CONFIG: begin
            dat_d[CFG_BITS_W-1:0] = bits_q;
            dat_d[CFG_EEDD_BIT]   = eedd_q;
            dat_d[CFG_EEDC_BIT]   = eedc_q;
          end
          SIA_RX_BAUDLO: dat_d = baud_q[SHIFT_REG_WIDTH-1:0];
          SIA_RX_BAUDHI: dat_d = baud_q[BAUD_RATE_WIDTH-1:SHIFT_REG_WIDTH];
          default: ;
        endcase
      end
    end

    // A new full edge outranks a same-cycle write-1-clear
    ovf_d       = (ovf_q & ~ovf_clr) | (rxq_full_i & ~full_prev_q);
    full_prev_d = rxq_full_i;
    irq_d       = ie_q & rxq_not_empty_i;
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= ST_IDLE;
      ack_q       <= 1'b0;
      stall_q     <= 1'b0;
      dat_q       <= '0;
      irq_q       <= 1'b0;
      bits_q      <= CFG_BITS_RST;
      baud_q      <= '0;
      eedd_q      <= 1'b0;
      eedc_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ie_q        <= 1'b0;
      full_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      stall_q     <= stall_d;
      dat_q       <= dat_d;
      irq_q       <= irq_d;
      bits_q      <= bits_d;
      baud_q      <= baud_d;
      eedd_q      <= eedd_d;
      eedc_q      <= eedc_d;
      ovf_q       <= ovf_d;
      ie_q        <= ie_d;
      full_prev_q <= full_prev_d;
    end
  end

  assign wb.ack_o   = ack_q;
  assign wb.stall_o = stall_q;
  assign wb.dat_o   = dat_q;
  assign irq_o      = irq_q;
  assign bits_o     = bits_q;
  assign baud_o     = baud_q;
  assign eedd_o     = eedd_q;
  assign eedc_o     = eedc_q;
  assign rxq_pop_o  = rd_pop;
  assign rxq_oe_o   = rd_pop;

endmodule

// File: tb/tb_sia_rx_wbs.sv
// Directed bench for sia_rx_wbs with a small FIFO model and read-data scoreboard.
module tb_sia_rx_wbs;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } sb_entry_t;

  logic        clk;
  logic        reset_i;
  logic        irq;
  logic [5:0]  bits;
  logic [31:0] baud;
  logic        eedd, eedc, pop, oe;
  logic [15:0] rxq_dat;
  logic        rxq_full, rxq_ne;

  logic [15:0] fmem [0:7];
  logic [3:0]  fcnt;

  sb_entry_t   sb [$];
  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;
  int unsigned exp_pops = 0;
  int unsigned mon_pops = 0;

  sia_rx_wbs_if #(.DW(16)) wb ();

  sia_rx_wbs #(.SHIFT_REG_WIDTH(16), .BAUD_RATE_WIDTH(32)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .wb              (wb),
    .irq_o           (irq),
    .bits_o          (bits),
    .baud_o          (baud),
    .eedd_o          (eedd),
    .eedc_o          (eedc),
    .rxq_pop_o       (pop),
    .rxq_oe_o        (oe),
    .rxq_dat_i       (rxq_dat),
    .rxq_full_i      (rxq_full),
    .rxq_not_empty_i (rxq_ne)
  );

  assign rxq_dat  = fmem[0];
  assign rxq_ne   = (fcnt != 4'd0);
  assign rxq_full = (fcnt >= 4'd4);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop pulses sampled mid-cycle, counted over the whole run
  always begin
    @(negedge clk);
    #2;
    if (pop === 1'b1) mon_pops++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_push(input logic [15:0] v);
    fmem[fcnt] = v;
    fcnt++;
  endtask

  task automatic fifo_push(input logic [15:0] v);
    @(negedge clk);
    do_push(v);
  endtask

  task automatic fifo_shift();
    for (int i = 0; i < 7; i++) fmem[i] = fmem[i+1];
    fcnt--;
  endtask

  // After the accepting edge: expect ACK in the next cycle, then a single pulse
  task automatic wait_ack(input string tag, input logic is_read);
    int unsigned n;
    sb_entry_t   e;
    n = 0;
    cyc_drop();
    check({tag, "_ack"}, {31'd0, wb.ack_o}, 32'd1);
    while (wb.ack_o !== 1'b1 && n < 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_stall"}, {31'd0, wb.stall_o}, {31'd0, wb.ack_o});
    if (is_read) begin
      e = sb.pop_front();
      check(e.tag, {16'd0, wb.dat_o}, {16'd0, e.val});
    end
    @(posedge clk);
    #1;
    check({tag, "_ack_pulse"}, {31'd0, wb.ack_o}, 32'd0);
  endtask

  task automatic cyc_drop();
    wb.cyc_i = 1'b0;
    wb.stb_i = 1'b0;
    wb.we_i  = 1'b0;
  endtask

  task automatic wb_write(input string tag, input logic [2:0] a, input logic [1:0] s,
                          input logic [15:0] d, input logic push_now, input logic [15:0] push_val);
    @(negedge clk);
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b1;
    wb.adr_i = a; wb.sel_i = s; wb.dat_i = d;
    if (push_now) do_push(push_val);
    #1;
    check({tag, "_idle_stall"}, {31'd0, wb.stall_o}, 32'd0);
    check({tag, "_wr_pop"}, {30'd0, pop, oe}, 32'd0);
    @(posedge clk);
    #1;
    wait_ack(tag, 1'b0);
  endtask

  task automatic wb_read(input string tag, input logic [2:0] a, input logic [15:0] exp_dat);
    logic pop_seen, exp_pop;
    sb.push_back('{tag, exp_dat});
    exp_pop = (a == 3'd0) && (fcnt != 4'd0);
    @(negedge clk);
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b0;
    wb.adr_i = a; wb.sel_i = 2'b11; wb.dat_i = 16'hDEAD;
    #1;
    pop_seen = pop;
    check({tag, "_pop"}, {31'd0, pop}, {31'd0, exp_pop});
    check({tag, "_oe"}, {31'd0, oe}, {31'd0, exp_pop});
    if (exp_pop) exp_pops++;
    @(posedge clk);
    #1;
    if (pop_seen === 1'b1 && fcnt != 4'd0) fifo_shift();
    wait_ack(tag, 1'b1);
  endtask

  function automatic logic [15:0] fifo_head();
    return (fcnt != 4'd0) ? fmem[0] : 16'h0000;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) fmem[i] = 16'h0000;
    fcnt     = 4'd0;
    reset_i  = 1'b0;
    wb.cyc_i = 1'b0; wb.stb_i = 1'b0; wb.we_i = 1'b0;
    wb.adr_i = 3'd0; wb.sel_i = 2'b00; wb.dat_i = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",   {31'd0, wb.ack_o},   32'd0);
    check("rst_stall", {31'd0, wb.stall_o}, 32'd0);
    check("rst_dat",   {16'd0, wb.dat_o},   32'd0);
    check("rst_bits",  {26'd0, bits},       32'd8);
    check("rst_baud",  baud,                32'd0);
    check("rst_edges", {30'd0, eedd, eedc}, 32'd0);
    check("rst_irq",   {31'd0, irq},        32'd0);
    @(negedge clk);
    reset_i = 1'b1;

    // Reset asserted while a read is being acknowledged
    wb_write("pre_cfg", 3'd2, 2'b11, 16'h0085, 1'b0, 16'h0);
    wb_write("pre_baud", 3'd3, 2'b11, 16'h00FF, 1'b0, 16'h0);
    @(negedge clk);
    wb.cyc_i = 1'b1; wb.stb_i = 1'b1; wb.we_i = 1'b0; wb.adr_i = 3'd2; wb.sel_i = 2'b11;
    @(posedge clk);
    #1;
    check("mid_ack_before_rst", {31'd0, wb.ack_o}, 32'd1);
    #1 reset_i = 1'b0;
    #1;
    check("mid_rst_ack",   {31'd0, wb.ack_o},   32'd0);
    check("mid_rst_stall", {31'd0, wb.stall_o}, 32'd0);
    check("mid_rst_dat",   {16'd0, wb.dat_o},   32'd0);
    check("mid_rst_bits",  {26'd0, bits},       32'd8);
    check("mid_rst_baud",  baud,                32'd0);
    check("mid_rst_edges", {30'd0, eedd, eedc}, 32'd0);
    cyc_drop();
    @(posedge clk);
    #1;
    check("mid_rst_noack", {31'd0, wb.ack_o}, 32'd0);
    @(negedge clk);
    reset_i = 1'b1;

    // Configuration
    wb_write("cfg_wr", 3'd2, 2'b11, 16'h00C7, 1'b0, 16'h0);
    check("cfg_bits", {26'd0, bits}, 32'd7);
    check("cfg_edges", {30'd0, eedd, eedc}, 32'd3);
    wb_read("cfg_rd", 3'd2, 16'h00C7);

    // Baud divisor halves and byte lanes
    wb_write("baudlo_wr", 3'd3, 2'b11, 16'h1234, 1'b0, 16'h0);
    wb_write("baudhi_wr", 3'd4, 2'b11, 16'h0001, 1'b0, 16'h0);
    check("baud_full", baud, 32'h0001_1234);
    wb_write("baudlo_lane", 3'd3, 2'b01, 16'hFFFF, 1'b0, 16'h0);
    check("baud_lane", baud, 32'h0001_12FF);
    wb_read("baudlo_rd", 3'd3, 16'h12FF);
    wb_read("baudhi_rd", 3'd4, 16'h0001);
    wb_write("unmapped_wr", 3'd6, 2'b11, 16'hFFFF, 1'b0, 16'h0);
    wb_read("unmapped_rd", 3'd6, 16'h0000);

    // FIFO drain
    fifo_push(16'h0041);
    fifo_push(16'h0042);
    wb_read("rx0", 3'd0, fifo_head());
    wb_read("rx1", 3'd0, fifo_head());
    wb_read("rx_empty", 3'd0, 16'h0000);
    wb_write("rxdat_wr", 3'd0, 2'b11, 16'h5A5A, 1'b0, 16'h0);

    // Overflow flag
    fifo_push(16'h000A);
    fifo_push(16'h000B);
    fifo_push(16'h000C);
    fifo_push(16'h000D);
    wb_read("stat_ovf", 3'd1, 16'h0007);
    wb_write("ovf_clr", 3'd1, 2'b11, 16'h0004, 1'b0, 16'h0);
    wb_read("stat_cleared", 3'd1, 16'h0003);
    wb_read("rx_drain0", 3'd0, fifo_head());
    wb_write("ovf_clr_vs_set", 3'd1, 2'b11, 16'h0004, 1'b1, 16'h000E);
    wb_read("stat_set_wins", 3'd1, 16'h0007);
    for (int i = 0; i < 4; i++) wb_read("rx_drain", 3'd0, fifo_head());
    wb_write("ie_set", 3'd1, 2'b11, 16'h000C, 1'b0, 16'h0);
    wb_read("stat_ie", 3'd1, 16'h0008);

    // Interrupt follows not_empty one cycle late
    check("irq_empty", {31'd0, irq}, 32'd0);
    fifo_push(16'h0055);
    #1;
    check("irq_lag", {31'd0, irq}, 32'd0);
    @(posedge clk);
    #1;
    check("irq_rise", {31'd0, irq}, 32'd1);
    wb_read("rx_irq", 3'd0, fifo_head());
    check("irq_fall", {31'd0, irq}, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    check("pop_total", mon_pops, exp_pops);
    check("sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
